// File: rtl/w0rm_peripheral_bus_master_if.sv
// CPU-side request/response and peripheral-side broadcast/return signals of the W0RM bus master.
// The master modport is the bus master's view; the slave modport is the CPU/extender side.
interface w0rm_peripheral_bus_master_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ERR_COUNT_WIDTH = 8
);
  logic                       cpu_valid_i;
  logic                       cpu_ready_o;
  logic                       cpu_write_i;
  logic [ADDR_WIDTH-1:0]      cpu_addr_i;
  logic [DATA_WIDTH-1:0]      cpu_data_i;
  logic                       cpu_result_valid_o;
  logic [DATA_WIDTH-1:0]      cpu_result_data_o;
  logic                       cpu_bus_error_o;
  logic [ERR_COUNT_WIDTH-1:0] err_count_o;
  logic                       bus_valid_o;
  logic                       bus_write_o;
  logic [ADDR_WIDTH-1:0]      bus_addr_o;
  logic [DATA_WIDTH-1:0]      bus_data_o;
  logic                       bus_valid_i;
  logic [DATA_WIDTH-1:0]      bus_data_i;

  modport master (
    input  cpu_valid_i, cpu_write_i, cpu_addr_i, cpu_data_i, bus_valid_i, bus_data_i,
    output cpu_ready_o, cpu_result_valid_o, cpu_result_data_o, cpu_bus_error_o,
           err_count_o, bus_valid_o, bus_write_o, bus_addr_o, bus_data_o
  );

  modport slave (
    output cpu_valid_i, cpu_write_i, cpu_addr_i, cpu_data_i, bus_valid_i, bus_data_i,
    input  cpu_ready_o, cpu_result_valid_o, cpu_result_data_o, cpu_bus_error_o,
           err_count_o, bus_valid_o, bus_write_o, bus_addr_o, bus_data_o
  );
endinterface

// File: rtl/w0rm_peripheral_bus_master.sv
// Single-outstanding W0RM peripheral bus master: one-cycle broadcast, merged response, timeout error.
//
// state    | meaning
// IDLE     | ready for a CPU request; stray responses ignored
// ISSUE    | bus_valid_o strobe for one cycle; timeout counter cleared
// WAIT_RSP | waiting for merged bus_valid_i or timeout
module w0rm_peripheral_bus_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int ERR_COUNT_WIDTH = 8
) (
  input  logic bus_clock,
  input  logic reset,
  w0rm_peripheral_bus_master_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       accept, rsp_ok, rsp_timeout;
  logic                       at_limit;

  logic                       bus_write_q;
  logic [ADDR_WIDTH-1:0]      bus_addr_q;
  logic [DATA_WIDTH-1:0]      bus_data_q;
  logic                       res_valid_q;
  logic                       res_error_q;
  logic [DATA_WIDTH-1:0]      res_data_q;
  logic [ERR_COUNT_WIDTH-1:0] err_cnt_q;

  assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge bus_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    rsp_ok      = 1'b0;
    rsp_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_valid_i) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        // a response in the last allowed cycle wins over the timeout
        if (bus.bus_valid_i) begin
          rsp_ok  = 1'b1;
          state_d = IDLE;
        end else if (at_limit) begin
          rsp_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clock or posedge reset) begin
    if (reset) begin
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_error_q <= 1'b0;
      res_data_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (accept) begin
        bus_write_q <= bus.cpu_write_i;
        bus_addr_q  <= bus.cpu_addr_i;
        bus_data_q  <= bus.cpu_data_i;
      end
      res_valid_q <= rsp_ok | rsp_timeout;
      res_error_q <= rsp_timeout;
      if (rsp_ok) begin
        res_data_q <= bus.bus_data_i;
      end else if (rsp_timeout) begin
        res_data_q <= '0;
      end
      if (rsp_timeout && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.cpu_ready_o        = (state_q == IDLE);
  assign bus.bus_valid_o        = (state_q == ISSUE);
  assign bus.bus_write_o        = bus_write_q;
  assign bus.bus_addr_o         = bus_addr_q;
  assign bus.bus_data_o         = bus_data_q;
  assign bus.cpu_result_valid_o = res_valid_q;
  assign bus.cpu_bus_error_o    = res_error_q;
  assign bus.cpu_result_data_o  = res_data_q;
  assign bus.err_count_o        = err_cnt_q;

endmodule

// File: tb/tb_w0rm_peripheral_bus_master.sv
// Bench for w0rm_peripheral_bus_master: vector table plus hand sequences, results checked via a scoreboard.
module tb_w0rm_peripheral_bus_master;
  localparam int T = 16;

  logic bus_clock = 1'b0;
  logic reset     = 1'b0;
  always #5 bus_clock = ~bus_clock;

  w0rm_peripheral_bus_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ERR_COUNT_WIDTH(8)) bif ();

  w0rm_peripheral_bus_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T), .ERR_COUNT_WIDTH(8)
  ) dut (
    .bus_clock(bus_clock),
    .reset(reset),
    .bus(bif.master)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;       // WAIT cycle index of the response; outside 0..T-1 means none
    logic [31:0] rdata;
    bit          stray_idle;
    bit          stray_issue;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] model_cnt = 8'd0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void push_exp(logic [31:0] d, bit e);
    if (e) model_cnt = (model_cnt == 8'hFF) ? 8'hFF : model_cnt + 8'd1;
    sb.push_back('{data: d, err: e, cnt: model_cnt});
  endfunction

  always @(negedge bus_clock) begin
    if (!reset && bif.cpu_result_valid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got pulse data 0x%08h expected none at %0t",
                 bif.cpu_result_data_o, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("result_data", bif.cpu_result_data_o, mon_e.data);
        chk("bus_error", {31'd0, bif.cpu_bus_error_o}, {31'd0, mon_e.err});
        chk("err_count", {24'd0, bif.err_count_o}, {24'd0, mon_e.cnt});
      end
    end
  end

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int dly, input logic [31:0] rdata, input bit stray_idle,
                        input bit stray_issue, input logic [31:0] exp_data, input bit exp_err);
    int n;
    if (stray_idle) begin
      bif.bus_valid_i = 1'b1;
      bif.bus_data_i  = 32'hDEAD_0001;
      @(negedge bus_clock);
      bif.bus_valid_i = 1'b0;
      chk("stray_idle_ready", {31'd0, bif.cpu_ready_o}, 32'd1);
    end
    n = 0;
    while (!bif.cpu_ready_o && n < 50) begin
      @(negedge bus_clock);
      n++;
    end
    chk("ready_before_req", {31'd0, bif.cpu_ready_o}, 32'd1);
    bif.cpu_valid_i = 1'b1;
    bif.cpu_write_i = wr;
    bif.cpu_addr_i  = addr;
    bif.cpu_data_i  = wdata;
    push_exp(exp_data, exp_err);
    @(negedge bus_clock);
    bif.cpu_valid_i = 1'b0;
    bif.cpu_addr_i  = $urandom;
    bif.cpu_data_i  = $urandom;
    bif.cpu_write_i = ~wr;
    chk("issue_valid", {31'd0, bif.bus_valid_o}, 32'd1);
    chk("issue_ready", {31'd0, bif.cpu_ready_o}, 32'd0);
    chk("issue_addr", bif.bus_addr_o, addr);
    chk("issue_data", bif.bus_data_o, wdata);
    chk("issue_write", {31'd0, bif.bus_write_o}, {31'd0, wr});
    if (stray_issue) begin
      bif.bus_valid_i = 1'b1;
      bif.bus_data_i  = 32'hDEAD_0002;
    end
    @(negedge bus_clock);
    bif.bus_valid_i = 1'b0;
    chk("wait_valid_low", {31'd0, bif.bus_valid_o}, 32'd0);
    chk("wait_addr_hold", bif.bus_addr_o, addr);
    if (dly >= 0 && dly < T) begin
      repeat (dly) @(negedge bus_clock);
      bif.bus_valid_i = 1'b1;
      bif.bus_data_i  = rdata;
      @(negedge bus_clock);
      bif.bus_valid_i = 1'b0;
      bif.bus_data_i  = $urandom;
      chk("done_pulse", {31'd0, bif.cpu_result_valid_o}, 32'd1);
      chk("done_ready", {31'd0, bif.cpu_ready_o}, 32'd1);
    end else begin
      n = 0;
      while (!bif.cpu_result_valid_o && n < 40) begin
        @(negedge bus_clock);
        n++;
      end
      chk("timeout_latency", n, T);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge bus_clock);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0,          1,  32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_2004, 32'h1234_5678, T,  32'h0,          1'b0, 1'b0, 32'h0,          1'b1};
    vecs[2] = '{1'b0, 32'h0000_3000, 32'h0,          T-1, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_4000, 32'h8765_4321, 0,  32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_5000, 32'h0,          3,  32'h1111_2222, 1'b1, 1'b1, 32'h1111_2222, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_6000, 32'h0,          -1, 32'h0,          1'b0, 1'b0, 32'h0,          1'b1};

    bif.cpu_valid_i = 1'b0;
    bif.cpu_write_i = 1'b0;
    bif.cpu_addr_i  = '0;
    bif.cpu_data_i  = '0;
    bif.bus_valid_i = 1'b0;
    bif.bus_data_i  = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bif.cpu_ready_o}, 32'd1);
    chk("rst_bus_valid", {31'd0, bif.bus_valid_o}, 32'd0);
    chk("rst_result_valid", {31'd0, bif.cpu_result_valid_o}, 32'd0);
    chk("rst_err_count", {24'd0, bif.err_count_o}, 32'd0);
    chk("rst_addr", bif.bus_addr_o, 32'd0);
    repeat (2) @(negedge bus_clock);
    reset = 1'b0;
    @(negedge bus_clock);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly, vecs[i].rdata,
             vecs[i].stray_idle, vecs[i].stray_issue, vecs[i].exp_data, vecs[i].exp_err);
      wait_drain();
      repeat (2) @(negedge bus_clock);
    end

    // back-to-back: second request raised in the completion cycle of the first
    do_txn(1'b0, 32'h0000_7000, 32'h0, 1, 32'h0BAD_BEEF, 1'b0, 1'b0, 32'h0BAD_BEEF, 1'b0);
    do_txn(1'b0, 32'h0000_7004, 32'h0, 0, 32'h1234_ABCD, 1'b0, 1'b0, 32'h1234_ABCD, 1'b0);
    wait_drain();

    // saturate the timeout counter
    for (int i = 0; i < 256; i++) begin
      do_txn(1'b1, 32'h0001_0000 + i, i, -1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    end
    wait_drain();
    chk("err_count_sat", {24'd0, bif.err_count_o}, 32'd255);
    do_txn(1'b0, 32'h0000_8000, 32'h0, T-1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0);
    wait_drain();

    // reset in the middle of WAIT abandons the transaction
    @(negedge bus_clock);
    bif.cpu_valid_i = 1'b1;
    bif.cpu_write_i = 1'b1;
    bif.cpu_addr_i  = 32'h0000_9000;
    bif.cpu_data_i  = 32'hFFFF_0000;
    @(negedge bus_clock);
    bif.cpu_valid_i = 1'b0;
    repeat (2) @(negedge bus_clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, bif.cpu_ready_o}, 32'd1);
    chk("mid_rst_bus_valid", {31'd0, bif.bus_valid_o}, 32'd0);
    chk("mid_rst_result_valid", {31'd0, bif.cpu_result_valid_o}, 32'd0);
    chk("mid_rst_result_data", bif.cpu_result_data_o, 32'd0);
    chk("mid_rst_err_count", {24'd0, bif.err_count_o}, 32'd0);
    chk("mid_rst_addr", bif.bus_addr_o, 32'd0);
    chk("mid_rst_data", bif.bus_data_o, 32'd0);
    chk("mid_rst_write", {31'd0, bif.bus_write_o}, 32'd0);
    model_cnt = 8'd0;
    @(negedge bus_clock);
    reset = 1'b0;
    repeat (20) @(negedge bus_clock);
    chk("post_rst_idle_ready", {31'd0, bif.cpu_ready_o}, 32'd1);
    do_txn(1'b0, 32'h0000_A000, 32'h0, 2, 32'h600D_D00D, 1'b0, 1'b0, 32'h600D_D00D, 1'b0);
    wait_drain();
    repeat (3) @(negedge bus_clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/w0rm_peripheral_bus_master.md
Name: w0rm_peripheral_bus_master

Overview:
- Single-outstanding request master for the W0RM peripheral bus.
- Accepts one load/store from the CPU memory stage and broadcasts it to all peripherals as a one-cycle strobe.
- Consumes the merged valid/data return produced by the 4-port bus extender.
- Returns the read data to the CPU, or a bus error if no peripheral answers within a timeout window.

Parameters:
DATA_WIDTH, 32, width of request write data and response data
ADDR_WIDTH, 32, width of peripheral address
TIMEOUT_CYCLES, 16, WAIT cycles allowed for a response (legal range 1..255)
ERR_COUNT_WIDTH, 8, width of saturating timeout counter

Ports:
bus_clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
cpu_valid_i  in  1  request strobe; accepted when cpu_ready_o=1
cpu_ready_o  out  1  high in IDLE only
cpu_write_i  in  1  1=store, 0=load
cpu_addr_i  in  ADDR_WIDTH  request address
cpu_data_i  in  DATA_WIDTH  store data
cpu_result_valid_o  out  1  one-cycle completion pulse
cpu_result_data_o  out  DATA_WIDTH  response data; 0 on error
cpu_bus_error_o  out  1  qualifies cpu_result_valid_o: timeout occurred
err_count_o  out  ERR_COUNT_WIDTH  saturating count of timeouts
bus_valid_o  out  1  one-cycle request strobe to peripherals
bus_write_o  out  1  latched cpu_write_i
bus_addr_o  out  ADDR_WIDTH  latched address
bus_data_o  out  DATA_WIDTH  latched store data
bus_valid_i  in  1  merged response valid from bus extender
bus_data_i  in  DATA_WIDTH  merged response data from bus extender

Behaviour:
- Reset (async assert, any state): state=IDLE, cpu_ready_o=1.
  - Zero: bus_valid_o, cpu_result_valid_o, cpu_bus_error_o, cpu_result_data_o, err_count_o, bus_write_o, bus_addr_o, bus_data_o, timeout counter.
  - An in-flight transaction is abandoned: no result pulse.
- IDLE: cpu_ready_o=1.
  - If cpu_valid_i=1: latch write/addr/data into bus_write_o/bus_addr_o/bus_data_o; -> ISSUE.
- ISSUE (exactly 1 cycle): bus_valid_o=1 and cpu_ready_o=0; timeout counter cleared; -> WAIT.
  - bus_valid_i is ignored in this cycle.
- WAIT: bus_valid_o=0, cpu_ready_o=0.
  - If bus_valid_i=1: next edge sets cpu_result_valid_o=1, cpu_result_data_o=bus_data_i, cpu_bus_error_o=0; -> IDLE.
  - Else if counter==TIMEOUT_CYCLES-1: next edge sets cpu_result_valid_o=1, cpu_result_data_o=0, cpu_bus_error_o=1; err_count_o increments (saturates at all-ones); -> IDLE.
  - Else counter increments.
  - A response arriving in the final allowed cycle is a success, not a timeout.
- Stores also wait for bus_valid_i as an acknowledge. The returned data is passed through unmodified.
- cpu_result_valid_o and cpu_bus_error_o are single-cycle pulses.
- cpu_result_data_o holds its value until the next completion.
- bus_addr_o, bus_data_o and bus_write_o hold their latched values until the next accepted request.
- Latency: request accepted at edge N; bus_valid_o high during cycle N+1; earliest response sampled at N+2; result pulse in cycle N+3.
- Back-to-back: cpu_ready_o is high in the same cycle as cpu_result_valid_o, so a new request may be accepted then.
- bus_valid_i in IDLE or ISSUE is a stray response: ignored, no state change.
- Counter width: enough bits for TIMEOUT_CYCLES-1; no wrap is possible.

Test Plan:
- Load addr 0x1000: bus_valid_i=1 with data 0xCAFEF00D two cycles after bus_valid_o -> single cpu_result_valid_o pulse, data 0xCAFEF00D, error 0, bus_valid_o high exactly 1 cycle with addr 0x1000.
- Store with no response, TIMEOUT_CYCLES=16 -> result pulse 16 cycles after leaving ISSUE; data 0, error 1, err_count_o 0->1.
- Response exactly in WAIT cycle 15 (last allowed) -> success, error 0, err_count_o unchanged. Response never, 256 times with ERR_COUNT_WIDTH=8 -> err_count_o saturates at 255.
- Two requests back-to-back, second asserted in the completion cycle of the first -> second accepted that edge, second bus_valid_o pulse 1 cycle later, correct data for each.
- bus_valid_i pulsed in IDLE and during the ISSUE cycle -> no result pulse, no state change; the real response later completes normally.
- reset asserted mid-WAIT -> bus_valid_o and all outputs 0 immediately (async), cpu_ready_o=1, no result pulse. After release a fresh load completes normally.
